sram_responder: RTL and testbench

//   Synthesizable emulation of the board's external asynchronous SRAM chip. It is
//   the responder end of the active-low en/oe/we + bidirectional data pin protocol

---
 rtl/sram_responder.sv | 155 +++++++++++++++
 tb/tb_sram_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Responder model of the board's asynchronous SRAM: active-low en/oe/we pins,
// shared tri-state data bus, internal backing array and protocol-violation flag.
module sram_responder #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en_in,
  input  logic              ram_oe_in,
  input  logic              ram_we_in,
  input  logic [ADDR_W-1:0] ram_address_in,
  inout  wire  [DATA_W-1:0] ram_data_inout,
  output logic [15:0]       write_count_out,
  output logic              conflict_out,
  output logic              busy_out
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    RD_DRIVE  = 3'd2,
    WR_ACTIVE = 3'd3,
    CONFLICT  = 3'd4
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W-1:0]       rd_addr_next;
  logic [DEPTH_LOG2-1:0]   hold_addr;
  logic [DATA_W-1:0]       hold_data;
  logic [DATA_W-1:0]       rd_data;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic rd_req_c;
  logic wr_req_c;
  logic clash_c;
  logic latch_c;
  logic commit_c;
  logic load_rd_c;
  logic drive_c;

  assign rd_req_c = ~ram_en_in & ~ram_oe_in &  ram_we_in;
  assign wr_req_c = ~ram_en_in &  ram_oe_in & ~ram_we_in;
  assign clash_c  = ~ram_en_in & ~ram_oe_in & ~ram_we_in;

  // Next-state, counter and capture control
  always_comb begin
    next_state   = state;
    cnt_next     = cnt;
    rd_addr_next = rd_addr;
    latch_c      = 1'b0;
    commit_c     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req_c) begin
          next_state   = RD_WAIT;
          cnt_next     = RELOAD;
          rd_addr_next = ram_address_in;
        end else if (wr_req_c) begin
          next_state = WR_ACTIVE;
          latch_c    = 1'b1;
        end else if (clash_c) begin
          next_state = CONFLICT;
        end
      end
      RD_WAIT: begin
        if (clash_c) begin
          next_state = CONFLICT;
        end else if (!rd_req_c) begin
          next_state = IDLE;
        end else if (ram_address_in != rd_addr) begin
          cnt_next     = RELOAD;
          rd_addr_next = ram_address_in;
        end else if (cnt == '0) begin
          next_state = RD_DRIVE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (clash_c) begin
          next_state = CONFLICT;
        end else if (!rd_req_c) begin
          next_state = IDLE;
        end else if (ram_address_in != rd_addr) begin
          next_state   = RD_WAIT;
          cnt_next     = RELOAD;
          rd_addr_next = ram_address_in;
        end
      end
      WR_ACTIVE: begin
        if (clash_c) begin
          next_state = CONFLICT;
        end else if (wr_req_c) begin
          latch_c = 1'b1;
        end else begin
          commit_c   = 1'b1;
          next_state = IDLE;
        end
      end
      CONFLICT: begin
        if (ram_en_in) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign load_rd_c = (next_state == RD_DRIVE) && (state != RD_DRIVE);

  // State, holding registers and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rd_addr         <= '0;
      hold_addr       <= '0;
      hold_data       <= '0;
      write_count_out <= '0;
      conflict_out    <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_next;
      rd_addr  <= rd_addr_next;
      busy_out <= (next_state != IDLE);
      if (latch_c) begin
        hold_addr <= ram_address_in[DEPTH_LOG2-1:0];
        hold_data <= ram_data_inout;
      end
      if (commit_c) write_count_out <= write_count_out + 16'(1);
      if (next_state == CONFLICT) conflict_out <= 1'b1;
    end
  end

  // Backing array is deliberately not reset; a reset cycle suppresses the commit
  always_ff @(posedge clk) begin
    if (commit_c && !rst) mem[hold_addr] <= hold_data;
    if (load_rd_c) rd_data <= mem[rd_addr[DEPTH_LOG2-1:0]];
  end

  // Drive gate stays combinational so the bus releases as soon as the pins drop
  assign drive_c        = (state == RD_DRIVE) & ~ram_en_in & ~ram_oe_in & ram_we_in;
  assign ram_data_inout = drive_c ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: writes, reads, aliasing, address change,
// conflict detection and reset behaviour.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, oe, we;
  logic [17:0] addr;
  logic [15:0] tb_data;
  logic        tb_drive;
  wire  [15:0] bus;
  logic [15:0] wcount;
  logic        conflict, busy;
  int          checks   = 0;
  int          failures = 0;

  assign bus = tb_drive ? tb_data : 16'hzzzz;

  sram_responder #(
    .DATA_W(16), .ADDR_W(18), .DEPTH_LOG2(10), .READ_LAT(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ram_en_in       (en),
    .ram_oe_in       (oe),
    .ram_we_in       (we),
    .ram_address_in  (addr),
    .ram_data_inout  (bus),
    .write_count_out (wcount),
    .conflict_out    (conflict),
    .busy_out        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    en = 1'b1; oe = 1'b1; we = 1'b1; tb_drive = 1'b0;
  endtask

  // Undriven reads as Z on a four-state simulator and as zero on a two-state one
  function automatic logic released(input logic [15:0] v);
    return (v === 16'h0000) || (v === 16'hzzzz);
  endfunction

  task automatic write_word(input logic [17:0] a, input logic [15:0] d, input int n);
    en = 1'b0; oe = 1'b1; we = 1'b0; addr = a; tb_data = d; tb_drive = 1'b1;
    repeat (n) tick();
    idle_pins();
    tick();
  endtask

  task automatic read_word(input logic [17:0] a, output logic [15:0] v);
    en = 1'b0; oe = 1'b0; we = 1'b1; addr = a; tb_drive = 1'b0;
    repeat (3) tick();
    v = bus;
    idle_pins();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_pins(); addr = '0; tb_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (!released(bus)) begin failures++; $display("FAIL reset_bus: got %h want Z", bus); end
    checks++; if (wcount !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", wcount); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict: got %b want 0", conflict); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write_read();
    en = 1'b0; oe = 1'b1; we = 1'b0; addr = 18'h00005; tb_data = 16'h1234; tb_drive = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b want 1", busy); end
    tick(); tick();
    idle_pins();
    tick();
    checks++; if (wcount !== 16'd1) begin failures++; $display("FAIL write_count1: got %0d want 1", wcount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_idle: got %b want 0", busy); end
    en = 1'b0; oe = 1'b0; we = 1'b1; addr = 18'h00005;
    tick(); tick();
    checks++; if (!released(bus)) begin failures++; $display("FAIL read_latency_early: got %h want Z", bus); end
    tick();
    checks++; if (bus !== 16'h1234) begin failures++; $display("FAIL read_after_write: got %h want 1234", bus); end
    idle_pins();
    tick();
  endtask

  task automatic test_alias();
    logic [15:0] v;
    write_word(18'h00005, 16'hBEEF, 2);
    checks++; if (wcount !== 16'd2) begin failures++; $display("FAIL alias_count: got %0d want 2", wcount); end
    read_word(18'h00405, v);
    checks++; if (v !== 16'hBEEF) begin failures++; $display("FAIL alias_read: got %h want beef", v); end
  endtask

  task automatic test_addr_change();
    write_word(18'h00006, 16'h5A5A, 1);
    checks++; if (wcount !== 16'd3) begin failures++; $display("FAIL addr6_count: got %0d want 3", wcount); end
    en = 1'b0; oe = 1'b0; we = 1'b1; addr = 18'h00005;
    repeat (3) tick();
    checks++; if (bus !== 16'hBEEF) begin failures++; $display("FAIL drive_addr5: got %h want beef", bus); end
    addr = 18'h00006;
    tick();
    checks++; if (!released(bus)) begin failures++; $display("FAIL addr_change_release: got %h want Z", bus); end
    tick();
    checks++; if (!released(bus)) begin failures++; $display("FAIL addr_change_wait: got %h want Z", bus); end
    tick();
    checks++; if (bus !== 16'h5A5A) begin failures++; $display("FAIL drive_addr6: got %h want 5a5a", bus); end
    oe = 1'b1;
    #1;
    checks++; if (!released(bus)) begin failures++; $display("FAIL oe_release_same_cycle: got %h want Z", bus); end
    idle_pins();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_end_idle: got %b want 0", busy); end
  endtask

  task automatic test_conflict();
    en = 1'b0; oe = 1'b0; we = 1'b0; addr = 18'h00005; tb_drive = 1'b0;
    tick();
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL clash_flag: got %b want 1", conflict); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clash_busy: got %b want 1", busy); end
    checks++; if (!released(bus)) begin failures++; $display("FAIL clash_bus: got %h want Z", bus); end
    idle_pins();
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clash_exit: got %b want 0", busy); end
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL clash_sticky: got %b want 1", conflict); end
    // Clash in the middle of a write discards that write
    en = 1'b0; oe = 1'b1; we = 1'b0; addr = 18'h00005; tb_data = 16'h1111; tb_drive = 1'b1;
    tick();
    oe = 1'b0;
    tick();
    idle_pins();
    tick();
    checks++; if (wcount !== 16'd3) begin failures++; $display("FAIL clash_discard_count: got %0d want 3", wcount); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL conflict_clear: got %b want 0", conflict); end
    checks++; if (wcount !== 16'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", wcount); end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] v;
    en = 1'b0; oe = 1'b1; we = 1'b0; addr = 18'h00006; tb_data = 16'h7777; tb_drive = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_pins();
    tick();
    checks++; if (wcount !== 16'd0) begin failures++; $display("FAIL midwrite_count: got %0d want 0", wcount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midwrite_busy: got %b want 0", busy); end
    read_word(18'h00006, v);
    checks++; if (v !== 16'h5A5A) begin failures++; $display("FAIL midwrite_array: got %h want 5a5a", v); end
    read_word(18'h00005, v);
    checks++; if (v !== 16'hBEEF) begin failures++; $display("FAIL discarded_write: got %h want beef", v); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_addr_change();
    test_conflict();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
